// File: rtl/conv2d_stream_core_if.sv
// Config, pixel-in and result-out signals of conv2d_stream_core.
// The core uses the slave modport; its driver uses the master modport.
interface conv2d_stream_core_if #(
  parameter int unsigned VALUE_BITS = 32,
  parameter int unsigned AW         = 6
);
  logic                  cfg_we;
  logic [AW-1:0]         cfg_addr;
  logic [VALUE_BITS-1:0] cfg_data;
  logic                  s_valid;
  logic                  s_ready;
  logic [VALUE_BITS-1:0] s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [VALUE_BITS-1:0] m_data;
  logic                  m_last;
  logic                  busy;
  logic                  done;

  modport master (
    output cfg_we, cfg_addr, cfg_data, s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last, busy, done
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last, busy, done
  );
endinterface

// File: rtl/conv2d_stream_core.sv
// Sequential valid-padding, stride-1 KxK conv2d: buffers one image, then one MAC per cycle
// per output, adds bias, saturates, optional ReLU, and streams results out.
module conv2d_stream_core #(
  parameter int unsigned IN_H       = 28,
  parameter int unsigned IN_W       = 28,
  parameter int unsigned IN_C       = 3,
  parameter int unsigned OUT_C      = 2,
  parameter int unsigned K          = 3,
  parameter int unsigned VALUE_BITS = 32,
  parameter int unsigned FRAC_BITS  = 16,
  parameter int unsigned RELU       = 1
) (
  input logic                 clk,
  input logic                 rst,
  conv2d_stream_core_if.slave bus
);
  localparam int unsigned OH    = IN_H - K + 1;
  localparam int unsigned OW    = IN_W - K + 1;
  localparam int unsigned KKC   = K * K * IN_C;
  localparam int unsigned NW    = OUT_C * KKC;
  localparam int unsigned NPIX  = IN_H * IN_W * IN_C;
  localparam int unsigned WAW   = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned PAW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int unsigned FW    = (OUT_C > 1) ? $clog2(OUT_C) : 1;
  // Guard bits so a sum of KKC full-scale products cannot wrap before saturation.
  localparam int unsigned ACC_W = 2 * VALUE_BITS + $clog2(KKC) + 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-VALUE_BITS+1){1'b0}},
                                                 {(VALUE_BITS-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-VALUE_BITS+1){1'b1}},
                                                 {(VALUE_BITS-1){1'b0}}};

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMac  = 2'd1;
  localparam logic [1:0] StFin  = 2'd2;
  localparam logic [1:0] StOut  = 2'd3;

  logic [1:0]                    r_state;
  logic [31:0]                   r_load_cnt, r_f, r_ox, r_oy, r_ky, r_kx, r_c;
  logic signed [ACC_W-1:0]       r_acc;
  logic [VALUE_BITS-1:0]         r_m_data;
  logic                          r_m_valid, r_done;
  logic signed [VALUE_BITS-1:0]  r_wmem [NW];
  logic signed [VALUE_BITS-1:0]  r_bmem [OUT_C];
  logic signed [VALUE_BITS-1:0]  r_img  [NPIX];

  logic [PAW-1:0]                w_pix_idx;
  logic [WAW-1:0]                w_wt_idx, w_cfg_widx;
  logic [FW-1:0]                 w_cfg_bidx;
  logic [31:0]                   w_cfg_addr;
  logic signed [VALUE_BITS-1:0]  w_wt, w_px, w_bias;
  logic signed [2*VALUE_BITS-1:0] w_prod;
  logic signed [ACC_W-1:0]       w_prod_ext, w_acc_base, w_sum, w_shift, w_bias_ext, w_r;
  logic [VALUE_BITS-1:0]         w_res;
  logic                          w_first, w_last_out, w_s_hs, w_cfg_en;

  assign w_pix_idx  = PAW'(((r_oy + r_ky) * IN_W + r_ox + r_kx) * IN_C + r_c);
  assign w_wt_idx   = WAW'(((r_f * K + r_ky) * K + r_kx) * IN_C + r_c);
  assign w_wt       = r_wmem[w_wt_idx];
  assign w_px       = r_img[w_pix_idx];
  assign w_bias     = r_bmem[r_f[FW-1:0]];
  assign w_prod     = w_wt * w_px;
  assign w_prod_ext = {{(ACC_W-2*VALUE_BITS){w_prod[2*VALUE_BITS-1]}}, w_prod};
  assign w_first    = (r_c == 0) && (r_kx == 0) && (r_ky == 0);
  assign w_acc_base = w_first ? '0 : r_acc;
  assign w_sum      = w_acc_base + w_prod_ext;
  assign w_shift    = r_acc >>> FRAC_BITS;
  assign w_bias_ext = {{(ACC_W-VALUE_BITS){w_bias[VALUE_BITS-1]}}, w_bias};
  assign w_r        = w_shift + w_bias_ext;

  always_comb begin
    w_res = w_r[VALUE_BITS-1:0];
    if (w_r > SAT_MAX) begin
      w_res = SAT_MAX[VALUE_BITS-1:0];
    end else if (w_r < SAT_MIN) begin
      w_res = SAT_MIN[VALUE_BITS-1:0];
    end
    if ((RELU != 0) && w_res[VALUE_BITS-1]) begin
      w_res = '0;
    end
  end

  assign w_last_out = (r_f == OUT_C - 1) && (r_ox == OW - 1) && (r_oy == OH - 1);
  assign w_s_hs     = bus.s_valid && (r_state == StIdle);
  assign w_cfg_en   = bus.cfg_we && (r_state == StIdle);
  assign w_cfg_addr = 32'(bus.cfg_addr);
  assign w_cfg_widx = WAW'(w_cfg_addr);
  assign w_cfg_bidx = FW'(w_cfg_addr - NW);

  assign bus.s_ready = (r_state == StIdle);
  assign bus.busy    = (r_state != StIdle);
  assign bus.m_valid = r_m_valid;
  assign bus.m_data  = r_m_data;
  assign bus.m_last  = r_m_valid && w_last_out;
  assign bus.done    = r_done;

  // Weight, bias and image storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_s_hs) begin
      r_img[r_load_cnt[PAW-1:0]] <= bus.s_data;
    end
    if (w_cfg_en && (w_cfg_addr < NW)) begin
      r_wmem[w_cfg_widx] <= bus.cfg_data;
    end
    if (w_cfg_en && (w_cfg_addr >= NW) && (w_cfg_addr < NW + OUT_C)) begin
      r_bmem[w_cfg_bidx] <= bus.cfg_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_load_cnt <= '0;
      r_f        <= '0;
      r_ox       <= '0;
      r_oy       <= '0;
      r_ky       <= '0;
      r_kx       <= '0;
      r_c        <= '0;
      r_acc      <= '0;
      r_m_data   <= '0;
      r_m_valid  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_s_hs) begin
            if (r_load_cnt == NPIX - 1) begin
              r_load_cnt <= '0;
              r_state    <= StMac;
            end else begin
              r_load_cnt <= r_load_cnt + 32'd1;
            end
          end
        end
        StMac: begin
          r_acc <= w_sum;
          if (r_c == IN_C - 1) begin
            r_c <= '0;
            if (r_kx == K - 1) begin
              r_kx <= '0;
              if (r_ky == K - 1) begin
                r_ky    <= '0;
                r_state <= StFin;
              end else begin
                r_ky <= r_ky + 32'd1;
              end
            end else begin
              r_kx <= r_kx + 32'd1;
            end
          end else begin
            r_c <= r_c + 32'd1;
          end
        end
        StFin: begin
          r_m_data  <= w_res;
          r_m_valid <= 1'b1;
          r_state   <= StOut;
        end
        StOut: begin
          if (bus.m_ready) begin
            r_m_valid <= 1'b0;
            if (w_last_out) begin
              r_done  <= 1'b1;
              r_f     <= '0;
              r_ox    <= '0;
              r_oy    <= '0;
              r_state <= StIdle;
            end else begin
              r_state <= StMac;
              if (r_f == OUT_C - 1) begin
                r_f <= '0;
                if (r_ox == OW - 1) begin
                  r_ox <= '0;
                  r_oy <= r_oy + 32'd1;
                end else begin
                  r_ox <= r_ox + 32'd1;
                end
              end else begin
                r_f <= r_f + 32'd1;
              end
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_conv2d_stream_core.sv
// Directed bench for conv2d_stream_core on a reduced 4x4x2 image, 2 filters, K=3;
// a RELU=1 and a RELU=0 core run in lockstep on the same stimulus.
module tb_conv2d_stream_core;
  localparam int unsigned IN_H  = 4;
  localparam int unsigned IN_W  = 4;
  localparam int unsigned IN_C  = 2;
  localparam int unsigned OUT_C = 2;
  localparam int unsigned K     = 3;
  localparam int unsigned VB    = 32;
  localparam int unsigned FRAC  = 16;
  localparam int unsigned OH    = IN_H - K + 1;
  localparam int unsigned OW    = IN_W - K + 1;
  localparam int unsigned KKC   = K * K * IN_C;
  localparam int unsigned NW    = OUT_C * KKC;
  localparam int unsigned NPIX  = IN_H * IN_W * IN_C;
  localparam int unsigned NOUT  = OH * OW * OUT_C;
  localparam int unsigned AW    = $clog2(NW + OUT_C);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv2d_stream_core_if #(.VALUE_BITS(VB), .AW(AW)) bus_r ();
  conv2d_stream_core_if #(.VALUE_BITS(VB), .AW(AW)) bus_l ();

  assign bus_l.cfg_we   = bus_r.cfg_we;
  assign bus_l.cfg_addr = bus_r.cfg_addr;
  assign bus_l.cfg_data = bus_r.cfg_data;
  assign bus_l.s_valid  = bus_r.s_valid;
  assign bus_l.s_data   = bus_r.s_data;
  assign bus_l.m_ready  = bus_r.m_ready;

  conv2d_stream_core #(
    .IN_H(IN_H), .IN_W(IN_W), .IN_C(IN_C), .OUT_C(OUT_C), .K(K),
    .VALUE_BITS(VB), .FRAC_BITS(FRAC), .RELU(1)
  ) u_dut_relu (
    .clk(clk),
    .rst(rst),
    .bus(bus_r)
  );

  conv2d_stream_core #(
    .IN_H(IN_H), .IN_W(IN_W), .IN_C(IN_C), .OUT_C(OUT_C), .K(K),
    .VALUE_BITS(VB), .FRAC_BITS(FRAC), .RELU(0)
  ) u_dut_lin (
    .clk(clk),
    .rst(rst),
    .bus(bus_l)
  );

  int n_err = 0;
  int n_chk = 0;
  logic [VB-1:0] got_r [NOUT];
  logic [VB-1:0] got_l [NOUT];
  logic          got_last [NOUT];
  logic [VB-1:0] exp_r [NOUT];
  logic [VB-1:0] exp_l [NOUT];
  int done_cnt, stall_err, ready_err, first_valid, n_got;

  task automatic chk(input string tag, input logic [VB-1:0] obs, input logic [VB-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cfg_wr(input int addr, input logic [VB-1:0] data);
    @(negedge clk);
    bus_r.cfg_we   = 1'b1;
    bus_r.cfg_addr = AW'(addr);
    bus_r.cfg_data = data;
    @(negedge clk);
    bus_r.cfg_we   = 1'b0;
  endtask

  // ident=1: only weight (f0,ky1,kx1,c0) = 1.0, index ((0*3+1)*3+1)*2+0 = 8.
  task automatic load_cfg(input bit ident, input logic [VB-1:0] wval,
                          input logic [VB-1:0] b0, input logic [VB-1:0] b1);
    for (int a = 0; a < int'(NW); a++) begin
      cfg_wr(a, ident ? ((a == 8) ? 32'h0001_0000 : 32'h0) : wval);
    end
    cfg_wr(int'(NW), b0);
    cfg_wr(int'(NW) + 1, b1);
  endtask

  task automatic send_image(input bit ramp, input logic [VB-1:0] cval);
    int i = 0;
    int guard = 0;
    while (i < int'(NPIX) && guard < 1000) begin
      @(negedge clk);
      guard++;
      bus_r.s_valid = 1'b1;
      bus_r.s_data  = ramp ? (VB'(i) << 16) : cval;
      if (bus_r.s_ready) i++;
    end
    chk("pixels_accepted", 32'(i), 32'(NPIX));
  endtask

  task automatic collect(input int ready_pct, input bit hold_valid, input int stop_at);
    int cyc = 0;
    logic [VB-1:0] held_d = '0;
    logic held_l = 1'b0;
    bit stalled = 1'b0;
    n_got = 0; done_cnt = 0; stall_err = 0; ready_err = 0; first_valid = -1;
    while (n_got < stop_at && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      bus_r.s_valid = hold_valid;
      if (hold_valid) bus_r.s_data = 32'hDEAD_BEEF;
      if (bus_r.done) done_cnt++;
      if (hold_valid && bus_r.busy && bus_r.s_ready) ready_err++;
      if (stalled && (bus_r.m_valid !== 1'b1 || bus_r.m_data !== held_d ||
                      bus_r.m_last !== held_l)) stall_err++;
      if (bus_r.m_valid && first_valid < 0) first_valid = cyc;
      bus_r.m_ready = ($urandom_range(99) < ready_pct);
      stalled = 1'b0;
      if (bus_r.m_valid) begin
        if (bus_r.m_ready) begin
          got_r[n_got]    = bus_r.m_data;
          got_l[n_got]    = bus_l.m_data;
          got_last[n_got] = bus_r.m_last;
          n_got++;
        end else begin
          stalled = 1'b1;
          held_d  = bus_r.m_data;
          held_l  = bus_r.m_last;
        end
      end
    end
    bus_r.s_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      bus_r.m_ready = 1'b0;
      if (bus_r.done) done_cnt++;
    end
    chk("outputs_received", 32'(n_got), 32'(stop_at));
  endtask

  // Identity kernel copies pixel (oy+1,ox+1,c0) into f0; f1 sees only its 0.5 bias.
  task automatic set_exp(input bit ident, input logic [VB-1:0] vr, input logic [VB-1:0] vl);
    for (int k = 0; k < int'(NOUT); k++) begin
      int f   = k % int'(OUT_C);
      int pos = k / int'(OUT_C);
      int ox  = pos % int'(OW);
      int oy  = pos / int'(OW);
      if (ident) begin
        exp_r[k] = (f == 0) ? (VB'(((oy + 1) * int'(IN_W) + ox + 1) * int'(IN_C)) << 16)
                            : 32'h0000_8000;
        exp_l[k] = exp_r[k];
      end else begin
        exp_r[k] = vr;
        exp_l[k] = vl;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int k = 0; k < int'(NOUT); k++) begin
      chk($sformatf("%s_relu[%0d]", tag, k), got_r[k], exp_r[k]);
      chk($sformatf("%s_lin[%0d]", tag, k), got_l[k], exp_l[k]);
      chk($sformatf("%s_last[%0d]", tag, k), 32'(got_last[k]), 32'(k == int'(NOUT) - 1));
    end
    chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    chk({tag, "_stall_stable"}, 32'(stall_err), 32'd0);
    chk({tag, "_idle_busy"}, 32'(bus_r.busy), 32'd0);
    chk({tag, "_idle_s_ready"}, 32'(bus_r.s_ready), 32'd1);
  endtask

  initial begin
    int guard;
    rst            = 1'b1;
    bus_r.cfg_we   = 1'b0;
    bus_r.cfg_addr = '0;
    bus_r.cfg_data = '0;
    bus_r.s_valid  = 1'b0;
    bus_r.s_data   = '0;
    bus_r.m_ready  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_s_ready", 32'(bus_r.s_ready), 32'd1);
    chk("rst_m_valid", 32'(bus_r.m_valid), 32'd0);
    chk("rst_m_last", 32'(bus_r.m_last), 32'd0);
    chk("rst_busy", 32'(bus_r.busy), 32'd0);
    chk("rst_done", 32'(bus_r.done), 32'd0);
    chk("rst_m_data", bus_r.m_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Identity kernel, ramp image, no backpressure; first result after 18 MAC + FIN + OUT.
    load_cfg(1'b1, 32'h0, 32'h0, 32'h0000_8000);
    send_image(1'b1, 32'h0);
    collect(100, 1'b0, int'(NOUT));
    set_exp(1'b1, 32'h0, 32'h0);
    check_outputs("ident");
    chk("first_latency", 32'(first_valid), 32'(KKC + 2));

    // All weights -1.0, pixels 1.0: sum is -18.0, clamped to 0 by ReLU.
    load_cfg(1'b0, 32'hFFFF_0000, 32'h0, 32'h0);
    send_image(1'b0, 32'h0001_0000);
    collect(100, 1'b0, int'(NOUT));
    set_exp(1'b0, 32'h0, 32'hFFEE_0000);
    check_outputs("relu");

    // Positive saturation under ~30% m_ready.
    load_cfg(1'b0, 32'h7FFF_FFFF, 32'h0, 32'h0);
    send_image(1'b0, 32'h7FFF_FFFF);
    collect(30, 1'b0, int'(NOUT));
    set_exp(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    check_outputs("sat_pos");

    // Negative saturation; config rewrite while busy must be dropped; s_valid held high.
    load_cfg(1'b0, 32'h8000_0001, 32'h0, 32'h0);
    send_image(1'b0, 32'h7FFF_FFFF);
    load_cfg(1'b0, 32'h0, 32'h1234_0000, 32'h1234_0000);
    collect(30, 1'b1, int'(NOUT));
    set_exp(1'b0, 32'h0, 32'h8000_0000);
    check_outputs("sat_neg_guard");
    chk("no_ready_while_busy", 32'(ready_err), 32'd0);

    // Next frame must still use the pre-guard weights.
    send_image(1'b0, 32'h7FFF_FFFF);
    collect(30, 1'b0, int'(NOUT));
    check_outputs("old_weights");

    // Abort during output #3, then reload and rerun the identity frame.
    load_cfg(1'b1, 32'h0, 32'h0, 32'h0000_8000);
    send_image(1'b1, 32'h0);
    collect(100, 1'b0, 3);
    guard = 0;
    while (!bus_r.m_valid && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("abort_pre_valid", 32'(bus_r.m_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_m_valid", 32'(bus_r.m_valid), 32'd0);
    chk("abort_s_ready", 32'(bus_r.s_ready), 32'd1);
    chk("abort_busy", 32'(bus_r.busy), 32'd0);
    chk("abort_m_data", bus_r.m_data, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    load_cfg(1'b1, 32'h0, 32'h0, 32'h0000_8000);
    send_image(1'b1, 32'h0);
    collect(100, 1'b0, int'(NOUT));
    set_exp(1'b1, 32'h0, 32'h0);
    check_outputs("after_abort");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
